tile_xy_inj_sched: RTL and testbench

- Injection scheduler for one tile's X/Y mesh write-request FIFO.
- Shares the single per-cycle injection slot among NREQ local requesters, e.g. 3 miss-issue ports plus writeback.
- Tracks per-direction (back/fwd) downstream FIFO credits so the 8-entry ring queues never overflow.
- Provides a drain sequence used before tile reconfiguration or flush.

---
 rtl/tile_xy_inj_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_tile_xy_inj_sched.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_xy_inj_sched.sv
// -----------------------------------------------------------------------------
// tile_xy_inj_sched
//
// Injection scheduler for one tile's X/Y mesh write-request FIFO. NREQ local
// requesters share the single per-cycle injection slot. Each request travels
// either "back" (target X <= TILE_X) or "fwd" (target X > TILE_X). A credit
// counter per direction keeps the downstream ring queues from overflowing.
// A drain sequence waits for all credits to return before tile
// reconfiguration or flush.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   req_valid     per-requester request pending
//   req_addr      per-requester address, packed NREQ x ADDR_W; [1:0] = target X
//   req_size      per-requester size/attributes, packed NREQ x SZ_W
//   req_ready     one-hot grant (combinational); transfer on valid & ready
//   inj_en        registered injection strobe, one cycle after the transfer
//   inj_addr      registered granted address (holds when inj_en = 0)
//   inj_size      registered granted size (holds when inj_en = 0)
//   inj_dir       registered granted direction, 0 = back, 1 = fwd
//   credit_ret    per-direction credit return pulse, [0] = back, [1] = fwd
//   drain_req     level drain request
//   drain_done    one-cycle pulse when the drain completes
//   credit_ovf    sticky: a credit came back while its counter was full
// -----------------------------------------------------------------------------
module tile_xy_inj_sched #(
   parameter int NREQ    = 4,
   parameter int CREDITS = 8,
   parameter int ADDR_W  = 37,
   parameter int SZ_W    = 12,
   parameter int TILE_X  = 0,
   parameter int AGE_MAX = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*SZ_W-1:0]   req_size,
   output logic [NREQ-1:0]        req_ready,
   output logic                   inj_en,
   output logic [ADDR_W-1:0]      inj_addr,
   output logic [SZ_W-1:0]        inj_size,
   output logic                   inj_dir,
   input  logic [1:0]             credit_ret,
   input  logic                   drain_req,
   output logic                   drain_done,
   output logic                   credit_ovf
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int AGE_W = (AGE_MAX > 1) ? $clog2(AGE_MAX + 1) : 1;

   localparam logic [3:0]       CRED_MAX = 4'(CREDITS);
   localparam logic [AGE_W-1:0] AGE_SAT  = AGE_W'(AGE_MAX);
   localparam logic [1:0]       TILE_X2  = 2'(TILE_X);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

   // ST_HOLD: a drain already completed for the current drain_req level;
   // it behaves like ST_DRAIN but never signals completion again, so a
   // fresh pulse needs drain_req to drop (back to RUN) and rise again.
   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_DONE,
      ST_HOLD
   } state_t;

   state_t             state_q;
   logic [3:0]         credit_q [2];
   logic [3:0]         credit_d [2];
   logic               ovf_hit;
   logic [PTR_W-1:0]   rr_ptr_q;
   logic [AGE_W-1:0]   age_q [NREQ];

   logic [NREQ-1:0]    req_dir;
   logic [NREQ-1:0]    elig;
   logic [NREQ-1:0]    starved;
   logic [NREQ-1:0]    grant_oh;
   logic               grant_any;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W-1:0]   rr_idx;
   logic               grant_dir;
   logic [ADDR_W-1:0]  grant_addr;
   logic [SZ_W-1:0]    grant_size;
   logic [1:0]         take;
   logic               all_home;

   // Per-requester direction, eligibility and starvation.
   // Nothing is eligible while rst is high, so no transfer is ever
   // signalled to a requester in a cycle whose effects reset discards.
   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         req_dir[i] = (req_addr[i*ADDR_W +: 2] > TILE_X2);
         elig[i]    = req_valid[i] && (credit_q[req_dir[i]] != '0) &&
                      (state_q == ST_RUN) && !rst;
         starved[i] = elig[i] && (age_q[i] >= AGE_SAT);
      end
   end

   // Selection: lowest-index starved requester wins outright; otherwise
   // the first eligible requester at or after rr_ptr, wrapping.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      rr_idx    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!grant_any && starved[i]) begin
            grant_any = 1'b1;
            grant_idx = PTR_W'(i);
         end
      end
      for (int unsigned k = 0; k < NREQ; k++) begin
         rr_idx = PTR_W'((32'(rr_ptr_q) + k) % NREQ);
         if (!grant_any && elig[rr_idx]) begin
            grant_any = 1'b1;
            grant_idx = rr_idx;
         end
      end
      if (grant_any) begin
         grant_oh[grant_idx] = 1'b1;
      end
   end

   assign req_ready = grant_oh;

   // Payload of the granted requester.
   always_comb begin
      grant_dir  = 1'b0;
      grant_addr = '0;
      grant_size = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_oh[i]) begin
            grant_dir  = req_dir[i];
            grant_addr = req_addr[i*ADDR_W +: ADDR_W];
            grant_size = req_size[i*SZ_W +: SZ_W];
         end
      end
   end

   assign take = {grant_any & grant_dir, grant_any & ~grant_dir};

   // Credit update: a grant and a return on the same direction cancel;
   // a lone return on a full counter is dropped and flagged.
   always_comb begin
      ovf_hit = 1'b0;
      for (int unsigned d = 0; d < 2; d++) begin
         credit_d[d] = credit_q[d];
         if (take[d] && !credit_ret[d]) begin
            credit_d[d] = credit_q[d] - 1'b1;
         end else if (credit_ret[d] && !take[d]) begin
            if (credit_q[d] == CRED_MAX) begin
               ovf_hit = 1'b1;
            end else begin
               credit_d[d] = credit_q[d] + 1'b1;
            end
         end
      end
   end

   assign all_home = (credit_q[0] == CRED_MAX) && (credit_q[1] == CRED_MAX) && !inj_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         credit_q[0] <= CRED_MAX;
         credit_q[1] <= CRED_MAX;
         rr_ptr_q    <= '0;
         for (int unsigned i = 0; i < NREQ; i++) begin
            age_q[i] <= '0;
         end
         inj_en      <= 1'b0;
         inj_addr    <= '0;
         inj_size    <= '0;
         inj_dir     <= 1'b0;
         drain_done  <= 1'b0;
         credit_ovf  <= 1'b0;
      end else begin
         inj_en <= grant_any;
         if (grant_any) begin
            inj_addr <= grant_addr;
            inj_size <= grant_size;
            inj_dir  <= grant_dir;
            rr_ptr_q <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
         end

         credit_q[0] <= credit_d[0];
         credit_q[1] <= credit_d[1];
         if (ovf_hit) begin
            credit_ovf <= 1'b1;
         end

         // Age counts cycles spent waiting with a request up, saturating.
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || grant_oh[i]) begin
               age_q[i] <= '0;
            end else if (age_q[i] != AGE_SAT) begin
               age_q[i] <= age_q[i] + 1'b1;
            end
         end

         drain_done <= 1'b0;
         case (state_q)
            ST_RUN: begin
               if (drain_req) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!drain_req) begin
                  state_q <= ST_RUN;
               end else if (all_home) begin
                  state_q    <= ST_DONE;
                  drain_done <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= drain_req ? ST_HOLD : ST_RUN;
            end
            ST_HOLD: begin
               if (!drain_req) begin
                  state_q <= ST_RUN;
               end
            end
            default: begin
               state_q <= ST_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tile_xy_inj_sched.sv
// -----------------------------------------------------------------------------
// tb_tile_xy_inj_sched
//
// Bench for tile_xy_inj_sched (TILE_X = 1, AGE_MAX = 3). A behavioural
// reference model runs in lockstep every cycle. Directed phases (vector
// table, drain sequence, credit overflow) additionally carry hand-derived
// expected values. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_tile_xy_inj_sched;

   localparam int NREQ    = 4;
   localparam int CREDITS = 8;
   localparam int ADDR_W  = 37;
   localparam int SZ_W    = 12;
   localparam int TILE_X  = 1;
   localparam int AGE_MAX = 3;

   logic                   clk;
   logic                   rst;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*SZ_W-1:0]   req_size;
   logic [NREQ-1:0]        req_ready;
   logic                   inj_en;
   logic [ADDR_W-1:0]      inj_addr;
   logic [SZ_W-1:0]        inj_size;
   logic                   inj_dir;
   logic [1:0]             credit_ret;
   logic                   drain_req;
   logic                   drain_done;
   logic                   credit_ovf;

   logic [ADDR_W-1:0]      a_addr [NREQ];
   logic [SZ_W-1:0]        a_size [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
      assign req_addr[gi*ADDR_W +: ADDR_W] = a_addr[gi];
      assign req_size[gi*SZ_W +: SZ_W]     = a_size[gi];
   end

   tile_xy_inj_sched #(
      .NREQ    (NREQ),
      .CREDITS (CREDITS),
      .ADDR_W  (ADDR_W),
      .SZ_W    (SZ_W),
      .TILE_X  (TILE_X),
      .AGE_MAX (AGE_MAX)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_size   (req_size),
      .req_ready  (req_ready),
      .inj_en     (inj_en),
      .inj_addr   (inj_addr),
      .inj_size   (inj_size),
      .inj_dir    (inj_dir),
      .credit_ret (credit_ret),
      .drain_req  (drain_req),
      .drain_done (drain_done),
      .credit_ovf (credit_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // ---------------- reference model ----------------
   int                m_cred [2];
   int                m_age  [NREQ];
   int                m_rr;
   int                m_phase;   // 0 run, 1 draining, 2 done cycle
   bit                m_spent;   // pulse already given for this drain_req level
   bit                m_en, m_dir, m_done, m_ovf;
   logic [ADDR_W-1:0] m_addr;
   logic [SZ_W-1:0]   m_size;

   function automatic void m_reset();
      m_cred[0] = CREDITS;
      m_cred[1] = CREDITS;
      for (int i = 0; i < NREQ; i++) m_age[i] = 0;
      m_rr = 0; m_phase = 0; m_spent = 0;
      m_en = 0; m_dir = 0; m_done = 0; m_ovf = 0;
      m_addr = '0; m_size = '0;
   endfunction

   function automatic int m_target_dir(int i);
      logic [1:0] t;
      t = a_addr[i][1:0];
      return (int'(t) > TILE_X) ? 1 : 0;
   endfunction

   function automatic bit m_eligible(int i);
      return req_valid[i] && (m_cred[m_target_dir(i)] > 0);
   endfunction

   function automatic int m_pick();
      if (rst || m_phase != 0) return -1;
      for (int i = 0; i < NREQ; i++)
         if (m_eligible(i) && m_age[i] >= AGE_MAX) return i;
      for (int k = 0; k < NREQ; k++)
         if (m_eligible((m_rr + k) % NREQ)) return (m_rr + k) % NREQ;
      return -1;
   endfunction

   function automatic void m_advance(int g);
      int  np;
      bit  home;
      bit  used, ret;
      if (rst) begin
         m_reset();
         return;
      end
      home   = (m_cred[0] == CREDITS) && (m_cred[1] == CREDITS) && !m_en;
      np     = m_phase;
      m_done = 0;
      case (m_phase)
         0: if (drain_req) begin np = 1; m_spent = 0; end
         1: begin
            if (!drain_req) np = 0;
            else if (!m_spent && home) begin np = 2; m_done = 1; end
         end
         default: begin
            if (drain_req) begin np = 1; m_spent = 1; end
            else np = 0;
         end
      endcase
      for (int d = 0; d < 2; d++) begin
         used = (g >= 0) && (m_target_dir(g) == d);
         ret  = credit_ret[d];
         if (used && !ret) m_cred[d]--;
         else if (ret && !used) begin
            if (m_cred[d] == CREDITS) m_ovf = 1;
            else m_cred[d]++;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!req_valid[i] || i == g) m_age[i] = 0;
         else if (m_age[i] < AGE_MAX) m_age[i]++;
      end
      m_en = (g >= 0);
      if (g >= 0) begin
         m_addr = a_addr[g];
         m_size = a_size[g];
         m_dir  = (m_target_dir(g) == 1);
         m_rr   = (g + 1) % NREQ;
      end
      m_phase = np;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // One clock cycle: inputs already applied. Compare at the falling edge,
   // advance the model, then return just after the rising edge.
   // Expectation arguments of -1 are not checked explicitly.
   task automatic step(input string tag, input int e_ready, input int e_en,
                       input int e_done, input int e_ovf);
      int              g;
      logic [NREQ-1:0] er;
      @(negedge clk);
      g  = m_pick();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      check({tag, " model req_ready"},  64'(req_ready),  64'(er));
      check({tag, " model inj_en"},     64'(inj_en),     64'(m_en));
      check({tag, " model inj_addr"},   64'(inj_addr),   64'(m_addr));
      check({tag, " model inj_size"},   64'(inj_size),   64'(m_size));
      check({tag, " model inj_dir"},    64'(inj_dir),    64'(m_dir));
      check({tag, " model drain_done"}, 64'(drain_done), 64'(m_done));
      check({tag, " model credit_ovf"}, 64'(credit_ovf), 64'(m_ovf));
      if (e_ready >= 0) check({tag, " req_ready"},  64'(req_ready),  64'(e_ready));
      if (e_en    >= 0) check({tag, " inj_en"},     64'(inj_en),     64'(e_en));
      if (e_done  >= 0) check({tag, " drain_done"}, 64'(drain_done), 64'(e_done));
      if (e_ovf   >= 0) check({tag, " credit_ovf"}, 64'(credit_ovf), 64'(e_ovf));
      m_advance(g);
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [1:0] tgt);
      logic [63:0] r;
      r = {$urandom, $urandom};
      a_addr[i] = {r[ADDR_W-1:2], tgt};
      a_size[i] = r[63 -: SZ_W];
   endtask

   task automatic drv(input logic [NREQ-1:0] v, input logic [7:0] tgts,
                      input logic [1:0] ret, input logic dr);
      req_valid = v;
      for (int i = 0; i < NREQ; i++) set_req(i, tgts[2*i +: 2]);
      credit_ret = ret;
      drain_req  = dr;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drv('0, 8'h00, 2'b00, 1'b0);
      step("reset", 0, -1, -1, -1);
      rst = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit              rst;
      logic [NREQ-1:0] valid;
      logic [7:0]      tgt;      // 2 bits of target X per requester
      logic [1:0]      ret;
      bit              drain;
      logic [NREQ-1:0] exp_ready;
      bit              exp_en;
   } vec_t;

   vec_t tbl [20];

   function automatic vec_t mk(bit r, logic [NREQ-1:0] v, logic [7:0] t,
                               logic [1:0] cr, bit dr, logic [NREQ-1:0] er, bit ee);
      vec_t x;
      x.rst = r; x.valid = v; x.tgt = t; x.ret = cr; x.drain = dr;
      x.exp_ready = er; x.exp_en = ee;
      return x;
   endfunction

   initial begin
      bit dr;

      // All four to fwd: round-robin 0,1,2,3,0,... until the 8 fwd credits
      // run out. Then one fwd return serves requester 2 alone. Then
      // requester 0 (fwd, exhausted) against requester 3 (back); rst discards.
      tbl[0]  = mk(0, 4'hF, 8'hAA, 2'b00, 0, 4'b0001, 0);
      tbl[1]  = mk(0, 4'hF, 8'hAA, 2'b00, 0, 4'b0010, 1);
      tbl[2]  = mk(0, 4'hF, 8'hAA, 2'b00, 0, 4'b0100, 1);
      tbl[3]  = mk(0, 4'hF, 8'hAA, 2'b00, 0, 4'b1000, 1);
      tbl[4]  = mk(0, 4'hF, 8'hAA, 2'b00, 0, 4'b0001, 1);
      tbl[5]  = mk(0, 4'hF, 8'hAA, 2'b00, 0, 4'b0010, 1);
      tbl[6]  = mk(0, 4'hF, 8'hAA, 2'b00, 0, 4'b0100, 1);
      tbl[7]  = mk(0, 4'hF, 8'hAA, 2'b00, 0, 4'b1000, 1);
      tbl[8]  = mk(0, 4'hF, 8'hAA, 2'b00, 0, 4'b0000, 1);
      tbl[9]  = mk(0, 4'h4, 8'hAA, 2'b10, 0, 4'b0000, 0);
      tbl[10] = mk(0, 4'h4, 8'hAA, 2'b00, 0, 4'b0100, 0);
      tbl[11] = mk(0, 4'h4, 8'hAA, 2'b00, 0, 4'b0000, 1);
      tbl[12] = mk(0, 4'h9, 8'h02, 2'b00, 0, 4'b1000, 0);
      tbl[13] = mk(0, 4'h9, 8'h02, 2'b00, 0, 4'b1000, 1);
      tbl[14] = mk(0, 4'h9, 8'h02, 2'b10, 0, 4'b1000, 1);
      tbl[15] = mk(0, 4'h9, 8'h02, 2'b00, 0, 4'b0001, 1);
      tbl[16] = mk(0, 4'h9, 8'h02, 2'b00, 0, 4'b1000, 1);
      tbl[17] = mk(1, 4'h9, 8'h02, 2'b00, 0, 4'b0000, 1);
      tbl[18] = mk(0, 4'h9, 8'h02, 2'b00, 0, 4'b0001, 0);
      tbl[19] = mk(0, 4'h0, 8'h02, 2'b00, 0, 4'b0000, 1);

      rst        = 1'b1;
      req_valid  = '0;
      credit_ret = '0;
      drain_req  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         a_addr[i] = '0;
         a_size[i] = '0;
      end
      @(posedge clk);
      #1;
      m_reset();
      step("reset0", 0, 0, 0, 0);
      step("reset1", 0, 0, 0, 0);
      rst = 1'b0;

      for (int r = 0; r < 20; r++) begin
         rst = tbl[r].rst;
         drv(tbl[r].valid, tbl[r].tgt, tbl[r].ret, tbl[r].drain);
         step($sformatf("vec%0d", r), int'(tbl[r].exp_ready), int'(tbl[r].exp_en), -1, -1);
      end
      rst = 1'b0;

      // Drain: three back injections, drain_req rises on the third,
      // three credits come back over five cycles.
      do_reset();
      drv(4'h1, 8'h00, 2'b00, 0); step("drn_g0", 1, 0, 0, -1);
      drv(4'h1, 8'h00, 2'b00, 0); step("drn_g1", 1, 1, 0, -1);
      drv(4'h1, 8'h00, 2'b00, 1); step("drn_g2", 1, 1, 0, -1);
      drv(4'h1, 8'h00, 2'b00, 1); step("drn_blk", 0, 1, 0, -1);
      drv(4'h1, 8'h00, 2'b01, 1); step("drn_r0", 0, 0, 0, -1);
      drv(4'h1, 8'h00, 2'b00, 1); step("drn_w0", 0, 0, 0, -1);
      drv(4'h1, 8'h00, 2'b01, 1); step("drn_r1", 0, 0, 0, -1);
      drv(4'h1, 8'h00, 2'b00, 1); step("drn_w1", 0, 0, 0, -1);
      drv(4'h1, 8'h00, 2'b01, 1); step("drn_r2", 0, 0, 0, -1);
      drv(4'h1, 8'h00, 2'b00, 1); step("drn_full", 0, 0, 0, -1);
      step("drn_done", 0, 0, 1, -1);
      step("drn_hold0", 0, 0, 0, -1);
      step("drn_hold1", 0, 0, 0, -1);
      drv(4'h1, 8'h00, 2'b00, 0); step("drn_exit", 0, 0, 0, -1);
      drv(4'h1, 8'h00, 2'b00, 0); step("drn_run", 1, 0, 0, -1);
      drv(4'h1, 8'h00, 2'b00, 1); step("abt_rise", 1, 1, 0, -1);
      drv(4'h1, 8'h00, 2'b00, 0); step("abt_drain", 0, 1, 0, -1);
      drv(4'h1, 8'h00, 2'b00, 0); step("abt_run", 1, 0, 0, -1);
      step("abt_nopulse", 1, 1, 0, -1);

      // Credits: grant+return on back cancels (no overflow), back counter
      // then has exactly 8; overflow on a return into a full counter.
      do_reset();
      drv(4'h1, 8'h00, 2'b01, 0); step("net_same", 1, -1, -1, 0);
      drv(4'h1, 8'h00, 2'b00, 0); step("net_chk", 1, 1, -1, 0);
      for (int k = 0; k < 7; k++) step("back_use", 1, 1, -1, 0);
      step("back_empty", 0, 1, -1, 0);
      drv(4'h0, 8'h00, 2'b01, 0);
      for (int k = 0; k < 8; k++) step("back_ret", 0, -1, -1, 0);
      step("ret_full", 0, 0, -1, 0);
      drv(4'h0, 8'h00, 2'b00, 0);
      step("ovf_set", 0, 0, -1, 1);
      step("ovf_sticky", 0, 0, -1, 1);
      drv(4'h1, 8'h00, 2'b00, 0);
      for (int k = 0; k < 8; k++) step("post_ovf_use", 1, -1, -1, 1);
      step("post_ovf_empty", 0, 1, -1, 1);

      // Randomized traffic against the model.
      dr = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         rst = ($urandom_range(999) < 3);
         if ($urandom_range(99) < 3) dr = !dr;
         req_valid = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) set_req(i, 2'($urandom));
         credit_ret = {($urandom_range(99) < 35), ($urandom_range(99) < 35)};
         drain_req  = dr;
         step("rand", -1, -1, -1, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
